uart_cmd_frame_assembler: RTL and testbench

//   Packs the byte stream from the UART receiver into 40-bit command words. Writes each complete word

---
 rtl/uart_cmd_frame_assembler.sv | 128 ++++++++++++
 tb/tb_uart_cmd_frame_assembler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_frame_assembler.sv
// Packs UART receive bytes into DATA_WIDTH-bit command words for the SRC command FIFO.
// It discards partial frames on inter-byte timeout or RX error, and drops complete frames when the FIFO is full.
module uart_cmd_frame_assembler #(
    parameter int DATA_WIDTH     = 40,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            rxByte_i,
    input  logic                  rxValid_i,
    input  logic                  rxError_i,
    input  logic                  fifoFull_i,
    output logic                  fifoWriteEnable_o,
    output logic [DATA_WIDTH-1:0] fifoWriteData_o,
    output logic                  frameDropped_o,
    output logic                  frameAborted_o,
    output logic [CNT_WIDTH-1:0]  dropCount_o,
    output logic                  diagValid_o
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t                state_q;
    logic [IDX_W-1:0]      byteIdx_q;
    logic [TO_W-1:0]       timeoutCnt_q;
    logic [DATA_WIDTH-1:0] shiftReg_q;
    logic                  writeEnable_q;
    logic [DATA_WIDTH-1:0] writeData_q;
    logic                  dropped_q;
    logic                  aborted_q;
    logic [CNT_WIDTH-1:0]  dropCount_q;
    logic                  diagValid_q;

    logic [DATA_WIDTH-1:0] word_d;
    logic [CNT_WIDTH-1:0]  dropCount_d;
    logic                  lastByte;
    logic                  timeoutHit;

    // Slot the incoming byte into its position; byte 0 lands in the top byte of the word.
    always_comb begin
        word_d = shiftReg_q;
        for (int b = 0; b < NBYTES; b++) begin
            if (IDX_W'(b) == byteIdx_q) begin
                word_d[DATA_WIDTH-1-8*b -: 8] = rxByte_i;
            end
        end
        lastByte    = (byteIdx_q == IDX_W'(NBYTES - 1));
        timeoutHit  = (timeoutCnt_q == TO_W'(TIMEOUT_CYCLES - 1));
        dropCount_d = (dropCount_q == '1) ? dropCount_q : dropCount_q + 1'b1;
    end

    // Priority is error over valid, and valid over timeout; byte index and shift register are zero in IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            byteIdx_q     <= '0;
            timeoutCnt_q  <= '0;
            shiftReg_q    <= '0;
            writeEnable_q <= 1'b0;
            writeData_q   <= '0;
            dropped_q     <= 1'b0;
            aborted_q     <= 1'b0;
            dropCount_q   <= '0;
            diagValid_q   <= 1'b0;
        end else begin
            writeEnable_q <= 1'b0;
            diagValid_q   <= 1'b0;
            dropped_q     <= 1'b0;
            aborted_q     <= 1'b0;
            if (rxError_i) begin
                if (state_q == COLLECT) begin
                    aborted_q   <= 1'b1;
                    dropCount_q <= dropCount_d;
                end
                state_q      <= IDLE;
                byteIdx_q    <= '0;
                timeoutCnt_q <= '0;
                shiftReg_q   <= '0;
            end else if (rxValid_i) begin
                timeoutCnt_q <= '0;
                if (lastByte) begin
                    state_q    <= IDLE;
                    byteIdx_q  <= '0;
                    shiftReg_q <= '0;
                    if (!fifoFull_i) begin
                        writeEnable_q <= 1'b1;
                        diagValid_q   <= 1'b1;
                        writeData_q   <= word_d;
                    end else begin
                        dropped_q   <= 1'b1;
                        dropCount_q <= dropCount_d;
                    end
                end else begin
                    state_q    <= COLLECT;
                    byteIdx_q  <= byteIdx_q + 1'b1;
                    shiftReg_q <= word_d;
                end
            end else if (state_q == COLLECT) begin
                if (timeoutHit) begin
                    aborted_q    <= 1'b1;
                    dropCount_q  <= dropCount_d;
                    state_q      <= IDLE;
                    byteIdx_q    <= '0;
                    timeoutCnt_q <= '0;
                    shiftReg_q   <= '0;
                end else begin
                    timeoutCnt_q <= timeoutCnt_q + 1'b1;
                end
            end
        end
    end

    assign fifoWriteEnable_o = writeEnable_q;
    assign fifoWriteData_o   = writeData_q;
    assign frameDropped_o    = dropped_q;
    assign frameAborted_o    = aborted_q;
    assign dropCount_o       = dropCount_q;
    assign diagValid_o       = diagValid_q;

endmodule

// File: tb/tb_uart_cmd_frame_assembler.sv
// Bench for the frame assembler: directed scenarios plus random traffic.
// A queue-based frame model predicts every output on every cycle.
module tb_uart_cmd_frame_assembler;

    localparam int DW  = 40;
    localparam int TO  = 8;
    localparam int CW  = 8;
    localparam int NB  = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    rxByte = '0;
    logic          rxValid = 1'b0;
    logic          rxError = 1'b0;
    logic          fifoFull = 1'b0;
    logic          writeEnable;
    logic [DW-1:0] writeData;
    logic          dropped;
    logic          aborted;
    logic [CW-1:0] dropCount;
    logic          diagValid;

    int checks = 0;
    int errors = 0;

    // The model keeps the frame as a queue of bytes held, and counts idle cycles since the last byte.
    logic [7:0]    heldBytes[$];
    int            idleCycles;
    logic          expWe, expDiag, expDropped, expAborted;
    logic [DW-1:0] expData;
    int            expCount;
    logic [DW-1:0] dutWrites[$];

    uart_cmd_frame_assembler #(
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .rxByte_i(rxByte),
        .rxValid_i(rxValid),
        .rxError_i(rxError),
        .fifoFull_i(fifoFull),
        .fifoWriteEnable_o(writeEnable),
        .fifoWriteData_o(writeData),
        .frameDropped_o(dropped),
        .frameAborted_o(aborted),
        .dropCount_o(dropCount),
        .diagValid_o(diagValid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic countDrop();
        if (expCount < (1 << CW) - 1) expCount++;
    endtask

    // Reference model: steps on each clock edge from the frame rules, cleared at once by reset.
    initial begin
        expWe = 0; expDiag = 0; expDropped = 0; expAborted = 0; expData = '0; expCount = 0;
        idleCycles = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                heldBytes.delete();
                idleCycles = 0;
                expWe = 0; expDiag = 0; expDropped = 0; expAborted = 0; expData = '0; expCount = 0;
            end else begin
                expWe = 0; expDiag = 0; expDropped = 0; expAborted = 0;
                if (rxError) begin
                    if (heldBytes.size() > 0) begin
                        expAborted = 1;
                        countDrop();
                    end
                    heldBytes.delete();
                    idleCycles = 0;
                end else if (rxValid) begin
                    heldBytes.push_back(rxByte);
                    idleCycles = 0;
                    if (heldBytes.size() == NB) begin
                        if (fifoFull) begin
                            expDropped = 1;
                            countDrop();
                        end else begin
                            expData = '0;
                            foreach (heldBytes[i]) expData = (expData << 8) | DW'(heldBytes[i]);
                            expWe = 1;
                            expDiag = 1;
                        end
                        heldBytes.delete();
                    end
                end else if (heldBytes.size() > 0) begin
                    idleCycles++;
                    if (idleCycles == TO) begin
                        expAborted = 1;
                        countDrop();
                        heldBytes.delete();
                        idleCycles = 0;
                    end
                end
            end
        end
    end

    // Compare every output on every falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("writeEnable", 64'(writeEnable), 64'(expWe));
            checkOutput("diagValid", 64'(diagValid), 64'(expDiag));
            checkOutput("writeData", 64'(writeData), 64'(expData));
            checkOutput("frameDropped", 64'(dropped), 64'(expDropped));
            checkOutput("frameAborted", 64'(aborted), 64'(expAborted));
            checkOutput("dropCount", 64'(dropCount), 64'(expCount));
            if (writeEnable) dutWrites.push_back(writeData);
        end
    end

    task automatic applyStimulus(input logic v, input logic [7:0] b, input logic e, input logic f);
        rxValid = v;
        rxByte = b;
        rxError = e;
        fifoFull = f;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic sendFrame(input logic [DW-1:0] word, input logic fullOnLast);
        logic [DW-1:0] w;
        w = word;
        for (int i = 0; i < NB; i++) begin
            applyStimulus(1'b1, w[DW-1 -: 8], 1'b0, (i == NB - 1) ? fullOnLast : 1'b0);
            w = w << 8;
        end
    endtask

    task automatic applyReset();
        #2 rst = 1'b1;
        rxValid = 0; rxError = 0; fifoFull = 0;
        @(negedge clk);
        checkOutput("resetWriteData", 64'(writeData), 64'h0);
        checkOutput("resetDropCount", 64'(dropCount), 64'h0);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkLastWrite(input string name, input int expSize, input logic [DW-1:0] word);
        checkOutput({name, "Count"}, 64'(dutWrites.size()), 64'(expSize));
        if (dutWrites.size() > 0) checkOutput(name, 64'(dutWrites[dutWrites.size() - 1]), 64'(word));
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        sendFrame(40'h1122334455, 1'b0);
        idle(2);
        checkLastWrite("frame1", 1, 40'h1122334455);

        sendFrame(40'hAAABACADAE, 1'b0);
        sendFrame(40'hB0B1B2B3B4, 1'b0);
        idle(2);
        checkLastWrite("backToBack", 3, 40'hB0B1B2B3B4);
        checkOutput("backToBackFirst", 64'(dutWrites[1]), 64'h00AAABACADAE);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0);
        idle(10);
        checkOutput("timeoutCount", 64'(dropCount), 64'd1);
        sendFrame(40'h0102030405, 1'b0);
        idle(2);
        checkLastWrite("afterTimeout", 4, 40'h0102030405);

        sendFrame(40'hDEADBEEF01, 1'b1);
        idle(2);
        checkOutput("fullDropCount", 64'(dropCount), 64'd2);
        for (int i = 0; i < NB; i++) applyStimulus(1'b1, 8'h60 + 8'(i), 1'b0, (i < NB - 1));
        idle(2);
        checkLastWrite("fullEarly", 5, 40'h6061626364);

        applyStimulus(1'b1, 8'h21, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
        sendFrame(40'h1011121314, 1'b0);
        idle(2);
        checkOutput("errorDropCount", 64'(dropCount), 64'd3);
        checkLastWrite("afterError", 6, 40'h1011121314);

        for (int i = 0; i < 800; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (i % 97 == 50) idle(TO + 1);
            applyStimulus((r >= 3) && (r < 65), 8'($urandom), r < 3, $urandom_range(0, 3) == 0);
        end
        idle(TO + 2);

        for (int i = 0; i < 130; i++) begin
            sendFrame(40'(i), 1'b1);
            applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        idle(2);
        checkOutput("saturated", 64'(dropCount), 64'd255);

        applyStimulus(1'b1, 8'hE1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hE2, 1'b0, 1'b0);
        applyReset();
        sendFrame(40'hC0C1C2C3C4, 1'b0);
        idle(2);
        checkOutput("postResetData", 64'(dutWrites[dutWrites.size() - 1]), 64'h00C0C1C2C3C4);
        checkOutput("postResetCount", 64'(dropCount), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
